alu_vector_gen: RTL
===================

# alu_vector_gen

Hardware test-vector source for the Hack ALU. It generates 56-bit ALU vectors with a valid/ready handshake, one per transfer, in the same bit packing the ALU checker consumes: `{x, y, zx, nx, zy, ny, f, no, out, zr, ng}`. Each vector's expected-result field comes from an internal reference model. The block sits between a start/status register and either an on-chip ALU checker or a UART dump path, replacing file-loaded vectors for board-level self-test.

## Interface
- `NUM_VECTORS`, default 18000: number of vectors per run (≥1).
- `SEED_X`, default 16'hACE1: reset/start seed of the x LFSR.
- `SEED_Y`, default 16'h1D2B: reset/start seed of the y LFSR.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: one-cycle pulse that begins a run; ignored while a run is in progress.
- `vec_valid`  out  1: `vec_data` holds a vector.
- `vec_ready`  in  1: consumer accepts; a transfer occurs on a cycle with `vec_valid && vec_ready`.
- `vec_data`  out  56: `[55:40]` x, `[39:24]` y, `[23:18]` zx,nx,zy,ny,f,no, `[17:2]` out, `[1]` zr, `[0]` ng.
- `busy`  out  1: a run is in progress.
- `done`  out  1: last run completed; sticky until the next accepted `start`.
- `count`  out  32: number of transfers in the current or last run.

## Operation
- States:
  - IDLE: after reset.
  - FILL: one cycle, pipeline priming.
  - RUN
  - DONE
- IDLE/DONE + `start` → FILL. On entry, both LFSRs are reseeded, the code index and `count` are cleared, and `done` is cleared.
- FILL → RUN unconditionally.
- RUN → DONE on the transfer that makes `count == NUM_VECTORS`.
- Code index `k` cycles 0..17 and wraps 17→0 after each generated vector. Code table, in order, as zx nx zy ny f no:
  - 0: 101010
  - 1: 111111
  - -1: 111010
  - x: 001100
  - y: 110000
  - !x: 001101
  - !y: 110001
  - -x: 001111
  - -y: 110011
  - x+1: 011111
  - y+1: 110111
  - x-1: 001110
  - y-1: 110010
  - x+y: 000010
  - x-y: 010011
  - y-x: 000111
  - x&y: 000000
  - x|y: 010101
- Operands come from the vector number `n`:
  - `n` 0..71 (corner phase): pair `n/18` is one of (0000,0000), (FFFF,FFFF), (8000,7FFF), (0001,FFFF).
  - Afterwards, operands are the LFSR values, and both LFSRs advance when `k` wraps.
  - If `NUM_VECTORS` < 72, the corner phase is truncated.
- LFSRs: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0. An all-zero state is never reachable from a nonzero seed.
- Reference model, all in 16-bit modular arithmetic:
  - x' = nx ? ~(zx?0:x) : (zx?0:x); y' likewise.
  - r = f ? x'+y' : x'&y'.
  - out = no ? ~r : r.
  - zr = (out==0); ng = out[15].

## Timing
- Reset values:
  - `vec_valid`=0, `vec_data`=0, `busy`=0, `done`=0, `count`=0, state IDLE.
  - LFSRs hold their seeds.
- Pipeline: generate stage → output register. It advances when `!vec_valid || vec_ready`.
- `start` sampled at edge t → `busy`=1 after t, `vec_valid`=1 after t+2.
- With `vec_ready` held high, there is one transfer per cycle, with no bubbles.
- While `vec_valid && !vec_ready`, `vec_data` is stable and no internal state advances.
- `vec_valid` never deasserts without a transfer, except on reset.
- `count` increments in the cycle after each transfer.
- Last transfer at edge t → `vec_valid`=0, `busy`=0, `done`=1, all after t.
- No vector is generated beyond `NUM_VECTORS`.
- `start` during FILL or RUN is ignored.
- `reset` mid-run → immediate return to the reset values; a partial vector is dropped.

## Structure
- Package `alu_tv_pkg` holds:
  - the code-table constant (18 × 6 bits);
  - field widths and offsets of the 56-bit vector;
  - the LFSR tap mask;
  - the corner operand pairs.
- Sub-module `alu_ref_model` (combinational: x, y, 6 control bits → out, zr, ng), instantiated once in the generate stage.

## Test plan
- Reset, `start`, `vec_ready`=1 → first vector is `vec_data`=56'h00000000A80002 (x=y=0, code "0", zr=1), two cycles after `start`.
- Free run → vector 25 (pair FFFF/FFFF, code -x) has x=FFFF, out=0001, zr=0, ng=0. Vector 47 (8000/7FFF, x-1) has out=7FFF, ng=0.
- Vector 67 (0001/FFFF, x+y) → out=0000, zr=1, ng=0. Vector 72 has x=SEED_X, y=SEED_Y.
- Hold `vec_ready`=0 for 5 cycles mid-run → `vec_data` is stable and `count` unchanged. On release, the next vector follows the same sequence as in an unstalled run.
- `NUM_VECTORS`=100 → exactly 100 transfers, then `done`=1, `count`=100, `vec_valid`=0. A second `start` reproduces the identical sequence.
- Assert `reset` after 30 transfers → all outputs go to their reset values. A new `start` restarts from vector 0.

Source files
------------

// File: rtl/alu_tv_pkg.sv
// Shared constants for the Hack ALU test-vector generator: code table,
// vector field layout, LFSR taps and corner operand pairs.
package alu_tv_pkg;

  localparam int VEC_W        = 56;
  localparam int OPND_W       = 16;
  localparam int CTRL_W       = 6;
  localparam int NUM_CODES    = 18;
  localparam int CORNER_PAIRS = 4;
  localparam int CORNER_LEN   = NUM_CODES * CORNER_PAIRS;

  localparam int X_LSB    = 40;
  localparam int Y_LSB    = 24;
  localparam int CTRL_LSB = 18;
  localparam int OUT_LSB  = 2;
  localparam int ZR_BIT   = 1;
  localparam int NG_BIT   = 0;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [OPND_W-1:0] LFSR_TAPS = 16'hB400;

  // zx nx zy ny f no, in generation order
  localparam logic [CTRL_W-1:0] CODE_TABLE [NUM_CODES] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  localparam logic [OPND_W-1:0] CORNER_X [CORNER_PAIRS] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001};
  localparam logic [OPND_W-1:0] CORNER_Y [CORNER_PAIRS] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'hFFFF};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } gen_state_e;

  function automatic logic [OPND_W-1:0] lfsr_next(input logic [OPND_W-1:0] s);
    return {s[OPND_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational Hack ALU reference: produces the expected out/zr/ng for a
// given operand pair and control code.
module alu_ref_model
  import alu_tv_pkg::*;
(
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [OPND_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [OPND_W-1:0] xz, yz, xp, yp, r;

  always_comb begin
    xz  = zx ? '0 : x;
    yz  = zy ? '0 : y;
    xp  = nx ? ~xz : xz;
    yp  = ny ? ~yz : yz;
    r   = f ? (xp + yp) : (xp & yp);
    out = no ? ~r : r;
    zr  = (out == '0);
    ng  = out[OPND_W-1];
  end

endmodule

// File: rtl/alu_vector_gen.sv
// Hack ALU test-vector source: corner-pair phase then LFSR operands, each
// vector packed with its reference result behind a valid/ready output register.
module alu_vector_gen
  import alu_tv_pkg::*;
#(
  parameter int          NUM_VECTORS = 18000,
  parameter logic [15:0] SEED_X      = 16'hACE1,
  parameter logic [15:0] SEED_Y      = 16'h1D2B
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [VEC_W-1:0] vec_data,
  output logic             busy,
  output logic             done,
  output logic [31:0]      count
);

  localparam logic [31:0] NUM_V      = 32'(NUM_VECTORS);
  localparam logic [31:0] CORNER_END = 32'(CORNER_LEN);
  localparam logic [4:0]  K_LAST     = 5'(NUM_CODES - 1);

  gen_state_e        state_q;
  logic [4:0]        k_p0;
  logic [31:0]       n_p0;
  logic [OPND_W-1:0] lfsr_x_p0, lfsr_y_p0;
  logic [OPND_W-1:0] opnd_x_p0, opnd_y_p0, out_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [1:0]        pair_p0;
  logic              zr_p0, ng_p0;
  logic [VEC_W-1:0]  vec_p0;
  logic [VEC_W-1:0]  data_p1;
  logic              vld_p1;
  logic              advance, load, xfer;

  // ---- generate stage (p0): operands, code and reference result ----
  always_comb begin
    if (n_p0 < 32'd18)      pair_p0 = 2'd0;
    else if (n_p0 < 32'd36) pair_p0 = 2'd1;
    else if (n_p0 < 32'd54) pair_p0 = 2'd2;
    else                    pair_p0 = 2'd3;
    if (n_p0 < CORNER_END) begin
      opnd_x_p0 = CORNER_X[pair_p0];
      opnd_y_p0 = CORNER_Y[pair_p0];
    end else begin
      opnd_x_p0 = lfsr_x_p0;
      opnd_y_p0 = lfsr_y_p0;
    end
    ctrl_p0 = CODE_TABLE[k_p0];
  end

  alu_ref_model u_ref (
    .x  (opnd_x_p0),
    .y  (opnd_y_p0),
    .zx (ctrl_p0[5]),
    .nx (ctrl_p0[4]),
    .zy (ctrl_p0[3]),
    .ny (ctrl_p0[2]),
    .f  (ctrl_p0[1]),
    .no (ctrl_p0[0]),
    .out(out_p0),
    .zr (zr_p0),
    .ng (ng_p0)
  );

  always_comb begin
    vec_p0                        = '0;
    vec_p0[X_LSB +: OPND_W]       = opnd_x_p0;
    vec_p0[Y_LSB +: OPND_W]       = opnd_y_p0;
    vec_p0[CTRL_LSB +: CTRL_W]    = ctrl_p0;
    vec_p0[OUT_LSB +: OPND_W]     = out_p0;
    vec_p0[ZR_BIT]                = zr_p0;
    vec_p0[NG_BIT]                = ng_p0;
  end

  assign advance = !vld_p1 || vec_ready;
  assign load    = advance && (state_q == ST_RUN) && (n_p0 < NUM_V);
  assign xfer    = vld_p1 && vec_ready;

  // ---- output register (p1) and run control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      k_p0      <= '0;
      n_p0      <= '0;
      lfsr_x_p0 <= SEED_X;
      lfsr_y_p0 <= SEED_Y;
    end else begin
      if (load) begin
        data_p1 <= vec_p0;
        vld_p1  <= 1'b1;
        n_p0    <= n_p0 + 32'd1;
        k_p0    <= (k_p0 == K_LAST) ? 5'd0 : k_p0 + 5'd1;
        // LFSR operands only start moving once the corner phase is over
        if (k_p0 == K_LAST && n_p0 >= CORNER_END) begin
          lfsr_x_p0 <= lfsr_next(lfsr_x_p0);
          lfsr_y_p0 <= lfsr_next(lfsr_y_p0);
        end
      end else if (xfer) begin
        vld_p1 <= 1'b0;
      end
      if (xfer) count <= count + 32'd1;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_FILL;
            busy      <= 1'b1;
            done      <= 1'b0;
            count     <= '0;
            k_p0      <= '0;
            n_p0      <= '0;
            lfsr_x_p0 <= SEED_X;
            lfsr_y_p0 <= SEED_Y;
          end
        end
        ST_FILL: state_q <= ST_RUN;
        ST_RUN: begin
          if (xfer && count == NUM_V - 32'd1) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vec_valid = vld_p1;
  assign vec_data  = data_p1;

endmodule
